// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/acknowledge bundle between the fetch stage and
// instruction memory.
//   imem_req   : fetch request, held until acknowledged   (master -> slave)
//   imem_addr  : word address of the request              (master -> slave)
//   imem_ack   : acknowledge, imem_rdata valid this cycle (slave  -> master)
//   imem_rdata : instruction word                         (slave  -> master)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the multi-cycle core. Owns the program counter,
// issues one instruction-memory request per FETCH phase, latches the returned
// word for decode, and updates the PC once on the first cycle of WRITE.
//
// Parameters:
//   RESET_PC        : PC value after reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   state           : global phase (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4)
//   imem            : instruction-memory handshake (fetch_unit_if.master)
//   instr_raw       : latched instruction word for decode
//   pc, pc_plus4    : current PC and its link value pc+4
//   fetch_done      : one-cycle pulse when instr_raw has been updated
//   branch_uc/_c    : unconditional / conditional branch from decode
//   branch_relative : 1 = target pc+imm, 0 = target alu_result (jalr)
//   imm, alu_result : branch offset, ALU result (bit 0 = compare outcome)
//   fetch_misalign  : sticky misaligned-target flag
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned taken targets are loaded as-is and set the sticky
//               fetch_misalign flag, which blocks further fetches until rst.
//   undefined : taken targets are forced word-aligned, fetch_misalign is 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  fetch_unit_if.master imem,
  output logic [31:0] instr_raw,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  input  logic        branch_uc,
  input  logic        branch_c,
  input  logic        branch_relative,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        fetch_misalign
);

  localparam logic [2:0] PH_FETCH = 3'd0;
  localparam logic [2:0] PH_WRITE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [2:0]  prev_state_q, prev_state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic        write_first;
  logic        taken;
  logic [31:0] target;

  assign pc_plus4    = pc_q + 32'd4;
  // Edge-detect on the phase so a multi-cycle WRITE updates the PC only once.
  assign write_first = (state == PH_WRITE) && (prev_state_q != PH_WRITE);
  assign taken       = branch_uc | (branch_c & alu_result[0]);
  assign target      = branch_relative ? (pc_q + imm) : {alu_result[31:1], 1'b0};

  always_comb begin
    fsm_d        = fsm_q;
    instr_d      = instr_q;
    done_d       = 1'b0;
    pc_d         = pc_q;
    misalign_d   = misalign_q;
    prev_state_d = state;

    case (fsm_q)
      IDLE: begin
        // A pending misalign trap parks the fetcher here until reset.
        if (state == PH_FETCH && !misalign_q) fsm_d = REQ;
      end
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          done_d  = 1'b1;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        // Wait for the phase to leave FETCH so one FETCH yields one fetch.
        if (state != PH_FETCH) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    if (write_first) begin
      if (taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        pc_d = target;
        if (target[1:0] != 2'b00) misalign_d = 1'b1;
`else
        pc_d = target & ~32'h3;
`endif
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      prev_state_q <= 3'd0;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= prev_state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem.imem_req  = (fsm_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr_raw      = instr_q;
  assign pc             = pc_q;
  assign fetch_done     = done_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [31:0] instr_raw, pc, pc_plus4;
  logic        fetch_done, fetch_misalign;
  logic        branch_uc, branch_c, branch_relative;
  logic [31:0] imm, alu_result;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .imem            (imem_bus),
    .instr_raw       (instr_raw),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_done      (fetch_done),
    .branch_uc       (branch_uc),
    .branch_c        (branch_c),
    .branch_relative (branch_relative),
    .imm             (imm),
    .alu_result      (alu_result),
    .fetch_misalign  (fetch_misalign)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] sb[$];

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic        uc, c, rel;
    logic [31:0] imm, alu, exp_pc;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each fetch_done must retire the oldest acknowledged word.
  always @(negedge clk) begin
    if (fetch_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fetch_done: got pulse expected none (instr_raw %h)", instr_raw);
      end else begin
        check("sb_instr_raw", instr_raw, sb.pop_front());
      end
    end
  end

  task automatic clear_ctrl();
    branch_uc = 1'b0; branch_c = 1'b0; branch_relative = 1'b0;
    imm = 32'd0; alu_result = 32'd0;
  endtask

  // Load an arbitrary aligned PC through a jalr-style WRITE.
  task automatic set_pc(input logic [31:0] v);
    state = 3'd4; branch_uc = 1'b1; branch_relative = 1'b0; alu_result = v;
    step();
    state = 3'd2; clear_ctrl();
    step();
    check("set_pc", pc, v);
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits, input int hold,
                          input logic [31:0] exp_addr);
    int d0;
    d0 = done_cnt;
    state = 3'd0;
    step();
    check("req_rise", {31'd0, imem_bus.imem_req}, 32'd1);
    check("req_addr", imem_bus.imem_addr, exp_addr);
    check("no_early_done", {31'd0, fetch_done}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      check("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
      check("addr_stable", imem_bus.imem_addr, exp_addr);
      check("no_done_wait", {31'd0, fetch_done}, 32'd0);
    end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = data;
    sb.push_back(data);
    step();
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check("fetch_done_pulse", {31'd0, fetch_done}, 32'd1);
    check("instr_raw", instr_raw, data);
    for (int i = 0; i < hold; i++) begin
      step();
      check("no_second_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("done_one_cycle", {31'd0, fetch_done}, 32'd0);
    end
    state = 3'd1;
    step();
    check("done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    vecs[0] = '{"bge_taken",   32'h200,      0, 1, 1, 32'hFFFF_FFF8, 32'h1,    32'h1F8};
    vecs[1] = '{"bge_not",     32'h200,      0, 1, 1, 32'hFFFF_FFF8, 32'h0,    32'h204};
    vecs[2] = '{"jalr",        32'h40,       1, 0, 0, 32'h0,         32'h1235, 32'h1234};
    vecs[3] = '{"wrap",        32'hFFFF_FFFC,0, 0, 1, 32'h0,         32'h0,    32'h0};
    vecs[4] = '{"jal",         32'h300,      1, 0, 1, 32'h20,        32'h0,    32'h320};
    vecs[5] = '{"cond_abs",    32'h80,       0, 1, 0, 32'h0,         32'h1001, 32'h1000};

    rst = 1'b1; state = 3'd1; clear_ctrl();
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'd0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_pc", pc, RST_PC);
    check("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    check("rst_instr_raw", instr_raw, 32'd0);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_done", {31'd0, fetch_done}, 32'd0);
    check("rst_misalign", {31'd0, fetch_misalign}, 32'd0);

    do_fetch(32'h0050_0093, 0, 2, RST_PC);
    do_fetch(32'h00A0_0113, 3, 6, RST_PC);

    foreach (vecs[i]) begin
      set_pc(vecs[i].start_pc);
      state = 3'd4;
      branch_uc = vecs[i].uc; branch_c = vecs[i].c; branch_relative = vecs[i].rel;
      imm = vecs[i].imm; alu_result = vecs[i].alu;
      step();
      state = 3'd2; clear_ctrl();
      check(vecs[i].name, pc, vecs[i].exp_pc);
      check("pc_plus4", pc_plus4, vecs[i].exp_pc + 32'd4);
      step();
    end

    // WRITE held for three cycles: only the first one moves the PC.
    set_pc(32'h40);
    state = 3'd4; branch_uc = 1'b1; branch_relative = 1'b0; alu_result = 32'h1235;
    for (int i = 0; i < 3; i++) begin
      step();
      check("write_held", pc, 32'h1234);
    end
    state = 3'd2; clear_ctrl();
    step();
    check("write_held_after", pc, 32'h1234);

    // Misaligned relative target.
    set_pc(32'h10);
    state = 3'd4; branch_uc = 1'b1; branch_relative = 1'b1; imm = 32'h6;
    step();
    state = 3'd2; clear_ctrl();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign_pc", pc, 32'h16);
    check("misalign_flag", {31'd0, fetch_misalign}, 32'd1);
    state = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("trap_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    state = 3'd1;
    step();
    check("misalign_sticky", {31'd0, fetch_misalign}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("misalign_cleared", {31'd0, fetch_misalign}, 32'd0);
`else
    check("misalign_pc", pc, 32'h14);
    check("misalign_flag", {31'd0, fetch_misalign}, 32'd0);
    step();
    do_fetch(32'h0000_0013, 0, 1, 32'h14);
`endif

    // Reset during the second REQ cycle; the late ack must be dropped.
    set_pc(32'h500);
    state = 3'd0;
    step();
    check("mid_req_rise", {31'd0, imem_bus.imem_req}, 32'd1);
    step();
    check("mid_req_2nd", {31'd0, imem_bus.imem_req}, 32'd1);
    rst = 1'b1; state = 3'd1;
    step();
    rst = 1'b0;
    check("rst_mid_req", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_bus.imem_ack = 1'b0;
    check("late_ack_instr", instr_raw, 32'd0);
    check("late_ack_done", {31'd0, fetch_done}, 32'd0);
    check("late_ack_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_mid_pc", pc, RST_PC);
    step();

    // Reset coinciding with the first WRITE cycle.
    set_pc(32'h700);
    state = 3'd4; branch_uc = 1'b1; branch_relative = 1'b0; alu_result = 32'h900;
    rst = 1'b1;
    step();
    rst = 1'b0; state = 3'd2; clear_ctrl();
    check("rst_wins_write", pc, RST_PC);
    step();
    check("rst_wins_write_hold", pc, RST_PC);

    step();
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle core; sits directly upstream of `decode`. It owns the program counter and fetches one instruction per FETCH phase over a variable-latency instruction-memory handshake. It presents the fetched word on `instr_raw` for DECODE, and updates the PC once per instruction in the WRITE phase from the branch controls that `decode` produces.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `state` in 3: global phase. FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: word address of the request; equals `pc`.
- `imem_ack` in 1: memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `instr_raw` out 32: latched instruction, fed to `decode`.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, combinational; used as the link value for jal/jalr.
- `fetch_done` out 1: one-cycle pulse when `instr_raw` has been updated; the controller advances FETCH→DECODE on it.
- `branch_uc` in 1: unconditional jump (jal/jalr), from `decode`.
- `branch_c` in 1: conditional branch (bge), from `decode`.
- `branch_relative` in 1: 1 selects target `pc + imm`; 0 selects `alu_result` (jalr).
- `imm` in 32: sign-extended branch offset, from `decode`.
- `alu_result` in 32: ALU output. Bit 0 is the compare outcome for `branch_c`; the full word is the jalr target.
- `fetch_misalign` out 1: sticky misaligned-target flag. Constant 0 unless `FETCH_MISALIGN_TRAP_EN` is defined.

## Operation

- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when `state==0` and no trap is pending.
  - REQ holds `imem_req=1` and a stable `imem_addr` until `imem_ack`.
  - On `imem_ack` in REQ: capture `instr_raw<=imem_rdata`, pulse `fetch_done`, go to DONE.
  - DONE → IDLE when `state!=0`. This guarantees exactly one fetch per FETCH phase, even if `state` stays 0 for extra cycles.
- `imem_ack` outside REQ is ignored.
- PC update happens once, on the first cycle of WRITE (`state==4` while the previous-cycle `state!=4`; the previous state is registered).
  - taken = `branch_uc | (branch_c & alu_result[0])`.
  - target = `branch_relative ? pc + imm : {alu_result[31:1],1'b0}`.
  - `pc <= taken ? target : pc + 4`.
- Arithmetic is 32-bit modulo 2^32; `pc + 4` from `32'hFFFF_FFFC` wraps to 0. No overflow flag.
- `instr_raw` holds its value outside REQ-with-ack. `decode` samples it during DECODE.

## Timing

- Reset values: `pc=RESET_PC`, `instr_raw=0`, `imem_req=0`, `fetch_done=0`, `fetch_misalign=0`, FSM=IDLE, registered previous state=0.
- `imem_req` rises the cycle after `state` becomes 0 (IDLE→REQ registered).
- Fetch latency: with `imem_ack` on the first REQ cycle, `fetch_done` pulses 2 cycles after FETCH entry. Each extra wait cycle adds 1.
- `fetch_done` is high for exactly 1 cycle per fetch.
- `rst` mid-REQ: `imem_req` is 0 on the cycle after `rst`. An ack arriving later is dropped and `instr_raw` is unchanged.
- If WRITE lasts several cycles, the PC updates only on its first cycle.
- `rst` and the first WRITE cycle together: reset wins, `pc=RESET_PC`.

## Configuration

- `FETCH_MISALIGN_TRAP_EN` defined:
  - On a taken branch whose target has bits [1:0]≠0, `pc` still loads the target and `fetch_misalign` sets.
  - `fetch_misalign` is sticky until `rst`. While it is set, the FSM stays in IDLE and issues no requests.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - The target is forced word-aligned (`target & ~32'h3`).
  - `fetch_misalign` is tied to 0.

## Test plan

- Reset with `RESET_PC=32'h100`, then `state=0`, ack on the first REQ cycle with `imem_rdata=32'h00500093`: `imem_addr=32'h100`, `instr_raw=32'h00500093`, `fetch_done` pulses once, 2 cycles after FETCH entry.
- Ack delayed 3 cycles and `state` held at 0 for 6 further cycles: `imem_addr` stays stable throughout, there is exactly one `fetch_done` pulse, and no second request.
- `pc=32'h200`, WRITE with `branch_c=1`, `alu_result=1`, `imm=-8`: `pc=32'h1F8`. Same case with `alu_result=0`: `pc=32'h204`.
- `pc=32'h40`, WRITE with jalr (`branch_uc=1`, `branch_relative=0`, `alu_result=32'h1235`): `pc=32'h1234`. WRITE held 3 cycles: `pc` changes only once.
- Macro on, `pc=32'h10`, jal with `imm=32'h6`: `pc=32'h16`, `fetch_misalign=1`, no `imem_req` in the next FETCH. Macro off, same stimulus: `pc=32'h14`, `fetch_misalign=0`.
- `rst` asserted in the 2nd REQ cycle, with the ack arriving one cycle later: `imem_req=0`, `instr_raw=0`, no `fetch_done`, `pc=RESET_PC`.
